alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, handshaked execution unit for the RV core. It extends the combinational integer ALU with the RISC-V M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) and sits in the execute stage between operand fetch and writeback. Base ops complete in one cycle. Multiply and divide run on an iterative shift/add datapath. Valid/ready handshakes on both sides let the pipeline stall on long operations.

## Interface
- XLEN, 32: datapath width; must be a power of two, minimum 8. Shift amount width is $clog2(XLEN).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request this cycle.
- instr  in  rv32i_instr_e  operation to perform.
- operand1, operand2, imm, pc  in  XLEN each  rs1, rs2, immediate and PC. Sampled only on accept.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer takes the result.
- result  out  XLEN  registered result.

## Operation
- Base ops have the same semantics as the existing ALU: AUIPC, LUI, ADD(I), SUB, XOR(I), OR(I), AND(I), SLL(I), SRL(I), SRA(I), SLT(I), SLTU/SLTIU.
  - SLT compares operand1 and operand2, signed.
  - SLTI compares operand1 and imm, signed.
  - SRA/SRAI are arithmetic shifts: sign bit replicated.
  - Unrecognised instr: result 0, 1-cycle latency.
- M ops follow the RISC-V M spec at width XLEN. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product.
- Signed mul/div: operands are converted to magnitudes on accept. The result is negated on the final iteration when the sign requires it.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
- Division special cases resolve at accept and take base-op latency:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → operand1.
  - Signed overflow (most negative / −1): DIV → operand1; REM → 0.
- FSM states:
  - IDLE (reset state): in_ready = 1. Accepting a base op or special-case div goes to DONE. Accepting an iterative M op goes to BUSY with the counter at 0.
  - BUSY: one iteration per cycle, restoring divide or shift-add multiply. When the counter reaches XLEN−1, the result is written and the state goes to DONE.
  - DONE: out_valid = 1 and result holds. If out_ready = 0, stay. If out_ready = 1 and in_valid = 0, go to IDLE. If out_ready = 1 and in_valid = 1, accept the new op in the same cycle.
- in_ready = (state == IDLE) || (state == DONE && out_ready). It does not depend on in_valid.
- rst at any time, including mid-BUSY, aborts the operation. State returns to IDLE, counter 0, out_valid 0, result 0.

## Timing
- Reset values: in_ready 1 (the cycle after rst deasserts), out_valid 0, result 0.
- Accept happens at edge N, when in_valid && in_ready.
  - Base ops: out_valid from N+1.
  - Iterative M ops: out_valid from N+1+XLEN.
- Back-to-back base ops with out_ready held high give one result per cycle.
- No combinational path from in_* to out_*. The only combinational path from out_ready is to in_ready.
- result and out_valid are stable while out_valid && !out_ready.

## Configuration
- Macro ALU_MDU_FAST_MUL_EN.
  - Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 2*XLEN multiplier and have base-op latency. Divide ops remain iterative.
  - Undefined: all M ops except division special cases take XLEN cycles in BUSY.

## Structure
- Package instruction_utils:
  - extend rv32i_instr_e with INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU, INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU;
  - add helper functions is_muldiv(instr) and is_signed_muldiv(instr);
  - add the FSM state typedef alu_mdu_state_e.
- Sub-module muldiv_iter: the iterative datapath, holding the accumulator/remainder, shifted operand register and iteration counter. It has start, done and sign-fix controls and is parametrised by XLEN.
- Top alu_mdu: base-op logic, special-case detection, FSM, handshakes, result register.

## Test plan
- ADD 5, 7 accepted at N → result 12 with out_valid at N+1. Back-to-back ADDs with out_ready = 1 → one result per cycle.
- SLT 0xFFFFFFFF vs 1 → 1. SLTU same operands → 0. SRA 0x80000000 by 4 → 0xF8000000.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MUL same operands → 0. Both have out_valid at N+33; with ALU_MDU_FAST_MUL_EN, at N+1.
- DIV 7/0 → 0xFFFFFFFF; REM 7/0 → 7; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0. All at N+1.
- DIV −7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF. out_ready held low 5 cycles → result stable and in_ready 0 until out_ready rises.
- rst asserted 10 cycles into a DIVU → next cycle out_valid 0, result 0, in_ready 1. A following ADD 1, 1 → 2 at N+1.

Source files
------------

// File: rtl/alu_mdu_pkg.sv
// Instruction encodings with RISC-V M-extension ops, mul/div helper predicates
// and the alu_mdu FSM state type.
package instruction_utils;

  typedef enum logic [5:0] {
    INSTR_AUIPC = 6'd0, INSTR_LUI, INSTR_ADD, INSTR_ADDI, INSTR_SUB,
    INSTR_XOR, INSTR_XORI, INSTR_OR, INSTR_ORI, INSTR_AND, INSTR_ANDI,
    INSTR_SLL, INSTR_SLLI, INSTR_SRL, INSTR_SRLI, INSTR_SRA, INSTR_SRAI,
    INSTR_SLT, INSTR_SLTI, INSTR_SLTU, INSTR_SLTIU,
    INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU,
    INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU,
    INSTR_ILLEGAL = 6'd63
  } rv32i_instr_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } alu_mdu_state_e;

  function automatic logic is_muldiv(input rv32i_instr_e instr);
    return instr inside {INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU,
                         INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU};
  endfunction

  function automatic logic is_signed_muldiv(input rv32i_instr_e instr);
    return instr inside {INSTR_MULH, INSTR_MULHSU, INSTR_DIV, INSTR_REM};
  endfunction

endpackage

// File: rtl/alu_mdu_muldiv_iter.sv
// Iterative magnitude datapath: shift-add multiply or restoring divide, one
// step per cycle, with optional negation applied to the final step's result.
module muldiv_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            step_i,
  input  logic            is_div_i,
  input  logic            sel_hi_i,
  input  logic            sign_fix_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod_fix;
  logic [XLEN-1:0]   opnd_q, opnd_d, half;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d, sel_hi_q, sel_hi_d, neg_q, neg_d;
  logic [XLEN:0]     sum, rem_sh;

  // acc holds {hi, lo}: product halves for multiply, {remainder, quotient} for divide
  always_comb begin
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    acc_step = '0;
    prod_fix = '0;
    half     = '0;
    if (is_div_q) begin
      if (rem_sh >= {1'b0, opnd_q}) begin
        acc_step = {XLEN'(rem_sh - {1'b0, opnd_q}), acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
      half     = sel_hi_q ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
      result_o = neg_q ? -half : half;
    end else begin
      if (acc_q[0]) begin
        acc_step = {sum, acc_q[XLEN-1:1]};
      end else begin
        acc_step = {1'b0, acc_q[2*XLEN-1:1]};
      end
      prod_fix = neg_q ? -acc_step : acc_step;
      result_o = sel_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
  end

  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sel_hi_d = sel_hi_q;
    neg_d    = neg_q;
    if (start_i) begin
      acc_d             = '0;
      acc_d[XLEN-1:0]   = op_a_i;
      opnd_d            = op_b_i;
      cnt_d             = '0;
      is_div_d          = is_div_i;
      sel_hi_d          = sel_hi_i;
      neg_d             = sign_fix_i;
    end else if (step_i) begin
      acc_d = acc_step;
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign done_o = step_i && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sel_hi_q <= sel_hi_d;
      neg_q    <= neg_d;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Handshaked ALU + RISC-V M execution unit. Define ALU_MDU_FAST_MUL_EN for a
// single-cycle multiplier; divides always use the iterative datapath.
module alu_mdu
  import instruction_utils::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  rv32i_instr_e    instr,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int unsigned SW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  alu_mdu_state_e  state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, base_res, mdu_res, mag_a, mag_b;
  logic [SW-1:0]   sh_reg, sh_imm;
  logic            accept, iterative, start, busy, mdu_done;
  logic            neg_a, neg_b, sign_fix, sel_hi;

`ifdef ALU_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] prod_a, prod_b, prod;

  always_comb begin
    prod_a = (instr inside {INSTR_MULH, INSTR_MULHSU}) ?
             {{XLEN{operand1[XLEN-1]}}, operand1} : {{XLEN{1'b0}}, operand1};
    prod_b = (instr == INSTR_MULH) ?
             {{XLEN{operand2[XLEN-1]}}, operand2} : {{XLEN{1'b0}}, operand2};
    prod   = prod_a * prod_b;
  end
`endif

  always_comb begin
    sh_reg    = operand2[SW-1:0];
    sh_imm    = imm[SW-1:0];
    neg_a     = is_signed_muldiv(instr) && operand1[XLEN-1];
    neg_b     = (instr inside {INSTR_MULH, INSTR_DIV, INSTR_REM}) && operand2[XLEN-1];
    mag_a     = neg_a ? -operand1 : operand1;
    mag_b     = neg_b ? -operand2 : operand2;
    sel_hi    = instr inside {INSTR_MULH, INSTR_MULHSU, INSTR_MULHU, INSTR_REM, INSTR_REMU};
    sign_fix  = (instr == INSTR_REM) ? neg_a : (neg_a ^ neg_b);
    iterative = is_muldiv(instr);
    base_res  = '0;
    case (instr)
      INSTR_AUIPC: base_res = pc + imm;
      INSTR_LUI:   base_res = imm;
      INSTR_ADD:   base_res = operand1 + operand2;
      INSTR_ADDI:  base_res = operand1 + imm;
      INSTR_SUB:   base_res = operand1 - operand2;
      INSTR_XOR:   base_res = operand1 ^ operand2;
      INSTR_XORI:  base_res = operand1 ^ imm;
      INSTR_OR:    base_res = operand1 | operand2;
      INSTR_ORI:   base_res = operand1 | imm;
      INSTR_AND:   base_res = operand1 & operand2;
      INSTR_ANDI:  base_res = operand1 & imm;
      INSTR_SLL:   base_res = operand1 << sh_reg;
      INSTR_SLLI:  base_res = operand1 << sh_imm;
      INSTR_SRL:   base_res = operand1 >> sh_reg;
      INSTR_SRLI:  base_res = operand1 >> sh_imm;
      INSTR_SRA:   base_res = XLEN'($signed(operand1) >>> sh_reg);
      INSTR_SRAI:  base_res = XLEN'($signed(operand1) >>> sh_imm);
      INSTR_SLT:   base_res = XLEN'($signed(operand1) < $signed(operand2));
      INSTR_SLTI:  base_res = XLEN'($signed(operand1) < $signed(imm));
      INSTR_SLTU:  base_res = XLEN'(operand1 < operand2);
      INSTR_SLTIU: base_res = XLEN'(operand1 < imm);
      INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU: begin
        if (operand2 == '0) begin
          base_res  = sel_hi ? operand1 : '1;
          iterative = 1'b0;
        end else if ((instr inside {INSTR_DIV, INSTR_REM}) &&
                     operand1 == MOST_NEG && operand2 == '1) begin
          base_res  = (instr == INSTR_DIV) ? operand1 : '0;
          iterative = 1'b0;
        end
      end
`ifdef ALU_MDU_FAST_MUL_EN
      INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU: begin
        base_res  = sel_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        iterative = 1'b0;
      end
`endif
      default: base_res = '0;
    endcase
  end

  muldiv_iter #(.XLEN(XLEN)) u_muldiv_iter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .step_i     (busy),
    .is_div_i   (instr inside {INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU}),
    .sel_hi_i   (sel_hi),
    .sign_fix_i (sign_fix),
    .op_a_i     (mag_a),
    .op_b_i     (mag_b),
    .done_o     (mdu_done),
    .result_o   (mdu_res)
  );

  // A new accept in DONE overrides the drop-to-IDLE decision made above it
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    start    = 1'b0;
    busy     = (state_q == ST_BUSY);
    in_ready = (state_q == ST_IDLE) || (state_q == ST_DONE && out_ready);
    accept   = in_valid && in_ready;
    case (state_q)
      ST_BUSY: begin
        if (mdu_done) begin
          result_d = mdu_res;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: if (out_ready && !in_valid) state_d = ST_IDLE;
      default: ;
    endcase
    if (accept) begin
      if (iterative) begin
        start   = 1'b1;
        state_d = ST_BUSY;
      end else begin
        result_d = base_res;
        state_d  = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomized self-checking bench for alu_mdu against an arithmetic reference model.
module tb_alu_mdu;
  import instruction_utils::*;

  localparam int unsigned XLEN = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready = 1'b1;
  rv32i_instr_e instr = INSTR_ADD;
  logic [31:0]  operand1 = '0, operand2 = '0, imm = '0, pc = '0;
  logic [31:0]  result;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .operand1  (operand1),
    .operand2  (operand2),
    .imm       (imm),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model(input rv32i_instr_e op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] im,
                                        input logic [31:0] p);
    longint sa, sb, ua, ub;
    logic [63:0] prod;
    bit ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      INSTR_AUIPC:  return p + im;
      INSTR_LUI:    return im;
      INSTR_ADD:    return a + b;
      INSTR_ADDI:   return a + im;
      INSTR_SUB:    return a - b;
      INSTR_XOR:    return a ^ b;
      INSTR_XORI:   return a ^ im;
      INSTR_OR:     return a | b;
      INSTR_ORI:    return a | im;
      INSTR_AND:    return a & b;
      INSTR_ANDI:   return a & im;
      INSTR_SLL:    return a << b[4:0];
      INSTR_SLLI:   return a << im[4:0];
      INSTR_SRL:    return a >> b[4:0];
      INSTR_SRLI:   return a >> im[4:0];
      INSTR_SRA:    return 32'(sa >>> b[4:0]);
      INSTR_SRAI:   return 32'(sa >>> im[4:0]);
      INSTR_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
      INSTR_SLTI:   return (sa < longint'($signed(im))) ? 32'd1 : 32'd0;
      INSTR_SLTU:   return (a < b) ? 32'd1 : 32'd0;
      INSTR_SLTIU:  return (a < im) ? 32'd1 : 32'd0;
      INSTR_MUL:    begin prod = ua * ub; return prod[31:0]; end
      INSTR_MULH:   begin prod = sa * sb; return prod[63:32]; end
      INSTR_MULHSU: begin prod = sa * ub; return prod[63:32]; end
      INSTR_MULHU:  begin prod = ua * ub; return prod[63:32]; end
      INSTR_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      INSTR_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      INSTR_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      INSTR_REMU:   return (b == 0) ? a : a % b;
      default:      return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input rv32i_instr_e op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op inside {INSTR_MUL, INSTR_MULH, INSTR_MULHSU, INSTR_MULHU}) begin
`ifdef ALU_MDU_FAST_MUL_EN
      return 1;
`else
      return XLEN + 1;
`endif
    end
    if (op inside {INSTR_DIV, INSTR_DIVU, INSTR_REM, INSTR_REMU}) begin
      if (b == 0) return 1;
      if ((op inside {INSTR_DIV, INSTR_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        return 1;
      return XLEN + 1;
    end
    return 1;
  endfunction

  // Issues one op with out_ready high, measures cycles to out_valid, checks latency and value.
  task automatic do_op(input rv32i_instr_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] p, input string tag,
                       output logic [31:0] res);
    int lat;
    bit seen;
    @(negedge clk);
    instr = op; operand1 = a; operand2 = b; imm = im; pc = p;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat(op, a, b)));
    check({tag, " result"}, result, model(op, a, b, im, p));
    res = result;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic [31:0] b2b_exp;
    int lat;
    bit seen;
    rv32i_instr_e rop;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);

    do_op(INSTR_ADD, 32'd5, 32'd7, '0, '0, "add", r);
    check("add const", r, 32'd12);

    b2b_exp = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check("b2b valid", 32'(out_valid), 32'd1);
        check("b2b result", result, b2b_exp);
      end
      if (k < 5) begin
        instr = INSTR_ADD; operand1 = $urandom; operand2 = $urandom;
        in_valid = 1'b1; out_ready = 1'b1;
        b2b_exp = operand1 + operand2;
        #1;
        check("b2b in_ready", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
    end

    do_op(INSTR_SLT,  32'hFFFF_FFFF, 32'd1, '0, '0, "slt", r);
    check("slt const", r, 32'd1);
    do_op(INSTR_SLTU, 32'hFFFF_FFFF, 32'd1, '0, '0, "sltu", r);
    check("sltu const", r, 32'd0);
    do_op(INSTR_SRA,  32'h8000_0000, 32'd4, '0, '0, "sra", r);
    check("sra const", r, 32'hF800_0000);
    do_op(INSTR_MULH, 32'h8000_0000, 32'h8000_0000, '0, '0, "mulh", r);
    check("mulh const", r, 32'h4000_0000);
    do_op(INSTR_MUL,  32'h8000_0000, 32'h8000_0000, '0, '0, "mul", r);
    check("mul const", r, 32'd0);
    do_op(INSTR_DIV,  32'd7, 32'd0, '0, '0, "div0", r);
    check("div0 const", r, 32'hFFFF_FFFF);
    do_op(INSTR_REM,  32'd7, 32'd0, '0, '0, "rem0", r);
    check("rem0 const", r, 32'd7);
    do_op(INSTR_DIV,  32'h8000_0000, 32'hFFFF_FFFF, '0, '0, "div ovf", r);
    check("div ovf const", r, 32'h8000_0000);
    do_op(INSTR_REM,  32'h8000_0000, 32'hFFFF_FFFF, '0, '0, "rem ovf", r);
    check("rem ovf const", r, 32'd0);
    do_op(INSTR_ILLEGAL, 32'd3, 32'd4, '0, '0, "illegal", r);
    check("illegal const", r, 32'd0);

    // DIV -7/2 with the consumer stalled
    @(negedge clk);
    instr = INSTR_DIV; operand1 = 32'hFFFF_FFF9; operand2 = 32'd2;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check("stall div latency", 32'(lat), 32'(XLEN + 1));
    check("stall div result", result, 32'hFFFF_FFFD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall out_valid", 32'(out_valid), 32'd1);
      check("stall result", result, 32'hFFFF_FFFD);
      check("stall in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("stall release in_ready", 32'(in_ready), 32'd1);
    do_op(INSTR_REM, 32'hFFFF_FFF9, 32'd2, '0, '0, "rem neg", r);
    check("rem neg const", r, 32'hFFFF_FFFF);

    // Abort a DIVU mid-flight
    do_op(INSTR_ADD, 32'd5, 32'd7, '0, '0, "pre-abort add", r);
    @(negedge clk);
    instr = INSTR_DIVU; operand1 = $urandom; operand2 = 32'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("busy in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort result", result, 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    do_op(INSTR_ADD, 32'd1, 32'd1, '0, '0, "post-abort add", r);
    check("post-abort const", r, 32'd2);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 19) == 0) rop = INSTR_ILLEGAL;
      else rop = rv32i_instr_e'(6'($urandom_range(0, 28)));
      do_op(rop, rnd_val(), rnd_val(), rnd_val(), $urandom, rop.name(), r);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
